// File: rtl/popcount27_vecgen_pkg.sv
// Shared constants, FSM state type and LFSR step function for the
// popcount27 known-count vector generator.
package popcount27_vecgen_pkg;

  localparam int N     = 27;
  localparam int CW    = 5;
  localparam int REM_W = 4;
  localparam int HALF  = 13;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10 (x^16+x^14+x^13+x^11+1).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/popcount27_vecgen_if.sv
// Request/response handshake bundle between a popcount stimulus consumer
// (master) and the vector generator (slave).
interface popcount27_vecgen_if;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [popcount27_vecgen_pkg::CW-1:0] in_count;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [popcount27_vecgen_pkg::N-1:0]  out_vec;
  logic [popcount27_vecgen_pkg::CW-1:0] out_count;
  logic                                 err_range;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_vec, out_count, err_range
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_vec, out_count, err_range
  );

endinterface

// File: rtl/popcount27_vecgen_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when enabled; reloads the seed
// on reset.
module popcount_lfsr16
  import popcount27_vecgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = en ? lfsr_next(lfsr_q) : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/popcount27_vecgen.sv
// Builds a 27-bit vector with exactly the requested number of ones at
// LFSR-chosen positions, so popcount cores can be driven with known answers.
module popcount27_vecgen
  import popcount27_vecgen_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  popcount27_vecgen_if.slave bus
);

  state_t             state_q, state_d;
  logic [N-1:0]       vec_q, vec_d;
  logic [CW-1:0]      count_q, count_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               pol_q, pol_d;
  logic               err_q, err_d;

  logic [15:0]        lfsr_q;
  logic               lfsr_en;
  logic               unused_lfsr;
  logic [31:0]        sel_onehot;
  logic [N-1:0]       bit_mask;
  logic               flip;
  logic [CW-1:0]      clamped;

  popcount_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign lfsr_en     = (state_q == FILL);
  assign unused_lfsr = ^lfsr_q[15:5];

  // Candidate positions 27..31 produce an empty mask and count as a skip.
  always_comb begin
    sel_onehot = 32'd1 << lfsr_q[4:0];
    bit_mask   = sel_onehot[N-1:0];
    flip       = 1'b0;
    if (bit_mask != '0) begin
      flip = pol_q ? ((vec_q & bit_mask) == '0) : ((vec_q & bit_mask) != '0);
    end
    clamped = (bus.in_count > CW'(N)) ? CW'(N) : bus.in_count;
  end

  // Counts above half start from all ones and clear bits, bounding FILL work.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    count_d = count_q;
    rem_d   = rem_q;
    pol_d   = pol_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          err_d   = (bus.in_count > CW'(N));
          count_d = clamped;
          if (clamped <= CW'(HALF)) begin
            vec_d = '0;
            pol_d = 1'b1;
            rem_d = clamped[REM_W-1:0];
          end else begin
            vec_d = '1;
            pol_d = 1'b0;
            rem_d = REM_W'(CW'(N) - clamped);
          end
          state_d = (rem_d == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (flip) begin
          vec_d = pol_q ? (vec_q | bit_mask) : (vec_q & ~bit_mask);
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      count_q <= '0;
      rem_q   <= '0;
      pol_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      pol_q   <= pol_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_vec   = vec_q;
  assign bus.out_count = count_q;
  assign bus.err_range = err_q;

endmodule
